mux8_operand_loader: RTL and testbench
======================================

# mux8_operand_loader

Upstream operand stage for the 8-bit 2:1 multiplexer lab datapath. It captures two 8-bit operands from the slide switches and drives a select bit under control of three push-buttons. Each button is synchronized and debounced, and a debounced press produces exactly one action. Outputs `x`, `y` and `s` feed the multiplexer's operand and select inputs directly. `LEDR[3:0]` reports loader status.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): number of consecutive clock cycles a synchronized key level must hold before it is accepted. Legal range is ≥ 1.

Ports:
- `CLOCK_50`  input  1  system clock; all logic is on its rising edge.
- `KEY0`  input  1  reset. Asynchronous, active-low (one clock; reset asynchronous active-low).
- `KEY1`  input  1  active-low button: load `x` from `SW`.
- `KEY2`  input  1  active-low button: load `y` from `SW`.
- `KEY3`  input  1  active-low button: toggle `s`.
- `SW`  input  8  operand source switches.
- `x`  output  8  registered operand A.
- `y`  output  8  registered operand B.
- `s`  output  1  registered select.
- `LEDR`  output  4  status: [0] x_loaded, [1] y_loaded, [2] copy of `s`, [3] ready (x_loaded & y_loaded).

## Operation
- **Synchronization:** `KEY1`–`KEY3` and `SW[7:0]` each pass through a 2-flop synchronizer. Key synchronizers reset to 1 (released); `SW` synchronizers reset to 0.
- **Debounce, per key:** there is one independent instance per key, holding a `stable` level (reset 1) and a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)` (reset 0).
  - If sync == `stable`, then `cnt` ← 0.
  - Else if `cnt` == `DEBOUNCE_CYCLES-1`, then `stable` ← sync and `cnt` ← 0.
  - Else `cnt` ← `cnt`+1.
- **Press event:** a press event is the edge on which `stable` changes 1→0. Release (0→1) is debounced the same way but produces no action.
- **KEY1 press:** `x` ← synchronized `SW` and x_loaded ← 1.
- **KEY2 press:** `y` ← synchronized `SW` and y_loaded ← 1.
- **KEY3 press:** `s` ← ~`s`.
- **Holding a key:** holding a key produces exactly one event. A second event requires a debounced release followed by a new debounced press.
- **Simultaneous events:** events on different keys in the same cycle all take effect in that cycle. KEY1+KEY2 together load the same `SW` value into both `x` and `y`.
- **Reloading:** reloading an already-loaded operand overwrites it. The loaded flags stay 1 until reset.
- **Reset values:** `x`=0, `y`=0, `s`=0, `LEDR`=4'b0000. All debounce state returns to released/0.
- **Reset mid-debounce or mid-press:** pending counts are discarded. A key still held when `KEY0` releases must be re-qualified for `DEBOUNCE_CYCLES` cycles and then generates one event.
- **No combinational paths:** no output depends combinationally on any input.

## Timing
- **Event latency:** let E0 be the first rising edge that samples the new key level. Sync output changes at E1; `stable`, and the resulting `x`/`y`/`s` update, occur at edge E(`DEBOUNCE_CYCLES`+1).
- **Bounce rejection:** a key level that reverts before being held for `DEBOUNCE_CYCLES` consecutive synchronized cycles produces no event, and its counter restarts at 0.
- **Operand value captured:** the value loaded is `SW` as sampled two edges before the load edge. `SW` must be stable for 2 cycles before the load edge; it is not debounced.
- **Outputs:** `LEDR` bits update on the same edge as the corresponding `x`/`y`/`s` change.
- **Reset assertion:** asserting `KEY0` low forces all outputs to their reset values immediately, without waiting for a clock edge. Deassertion is recognized on the next rising edge.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
1. **Reset:** hold `KEY0`=0 with `SW`=8'hFF and random keys → `x`=0, `y`=0, `s`=0, `LEDR`=0 throughout, including between clock edges.
2. **Load x:** `SW`=8'hA5, then `KEY1` low from edge E0 and held → `x`=8'hA5 and `LEDR[0]`=1 exactly at E5; `x` unchanged after a further 20 held cycles.
3. **Bounce rejection and load y:**
   - Toggle `KEY2` low 3 cycles / high 1 cycle, repeated 5 times → no change to `y`.
   - Then hold `KEY2` low with `SW`=8'h3C → `y`=8'h3C, `LEDR[1]`=1 and `LEDR[3]`=1 (after step 2).
4. **Select toggle:** press/release `KEY3` three times, each phase 10 cycles → `s` and `LEDR[2]` go 1, 0, 1. No toggle occurs on release.
5. **Simultaneous press:** `KEY1` and `KEY2` fall on the same edge with `SW`=8'h5A → `x`=`y`=8'h5A on the same edge E5.
6. **Reset mid-press:**
   - Assert `KEY0` at E2 of a `KEY1` press → no load occurs.
   - Release `KEY0` with `KEY1` still held → `x` loads exactly 5 edges after reset deassertion, once.

Source files
------------

// File: rtl/mux8_operand_loader.sv
// Operand loader for the 8-bit 2:1 mux lab: three debounced push-buttons load x/y from SW and toggle s.
// All inputs are synchronized; every output is driven from registers only.
module mux8_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic       KEY2,
  input  logic       KEY3,
  input  logic [7:0] SW,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       s,
  output logic [3:0] LEDR
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0] key_meta;
  logic [2:0] key_sync;
  logic [7:0] sw_meta;
  logic [7:0] sw_sync;
  logic [2:0] press;
  logic       x_loaded;
  logic       y_loaded;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // Key synchronizers reset to the released level so reset never fakes a press.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      key_meta <= '1;
      key_sync <= '1;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      key_meta <= {KEY3, KEY2, KEY1};
      key_sync <= key_meta;
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
    end
  end

  // Index 0 = KEY1 (load x), 1 = KEY2 (load y), 2 = KEY3 (toggle s).
  for (genvar i = 0; i < 3; i++) begin : g_debounce
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
        stable <= 1'b1;
        cnt    <= '0;
      end else if (key_sync[i] == stable) begin
        cnt    <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= key_sync[i];
        cnt    <= '0;
      end else begin
        cnt    <= cnt + CW'(1);
      end
    end

    // The press fires on the very edge where stable falls 1->0, so the action lands on that edge too.
    assign press[i] = stable & ~key_sync[i] & (cnt == CNT_LAST);
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      x        <= '0;
      y        <= '0;
      s        <= 1'b0;
      x_loaded <= 1'b0;
      y_loaded <= 1'b0;
    end else begin
      if (press[0]) begin
        x        <= sw_sync;
        x_loaded <= 1'b1;
      end
      if (press[1]) begin
        y        <= sw_sync;
        y_loaded <= 1'b1;
      end
      if (press[2]) s <= ~s;
    end
  end

  assign LEDR = {x_loaded & y_loaded, s, y_loaded, x_loaded};

endmodule

// File: tb/tb_mux8_operand_loader.sv
// Bench for mux8_operand_loader with DEBOUNCE_CYCLES=4: expected output updates are queued with
// their target edge and popped when the DUT outputs change.
module tb_mux8_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key1 = 1'b1;
  logic       key2 = 1'b1;
  logic       key3 = 1'b1;
  logic [7:0] sw = '0;
  logic [7:0] x;
  logic [7:0] y;
  logic       s;
  logic [3:0] ledr;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  typedef struct {
    int         at_edge;
    logic [20:0] outs;
  } exp_t;

  exp_t        sb[$];
  logic [20:0] snap = '0;

  logic [7:0] mx = '0;
  logic [7:0] my = '0;
  logic       ms = 1'b0;
  logic       mxl = 1'b0;
  logic       myl = 1'b0;

  mux8_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(clk),
    .KEY0    (rst_n),
    .KEY1    (key1),
    .KEY2    (key2),
    .KEY3    (key3),
    .SW      (sw),
    .x       (x),
    .y       (y),
    .s       (s),
    .LEDR    (ledr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [20:0] model_outs();
    return {mx, my, ms, mxl & myl, ms, myl, mxl};
  endfunction

  function automatic logic [20:0] dut_outs();
    return {x, y, s, ledr};
  endfunction

  // Steps falling edges until the outputs differ from the last observed snapshot or the budget expires.
  task automatic wait_change(input int budget, output bit seen, output int at);
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dut_outs() !== snap) begin
        seen = 1'b1;
        at   = edge_cnt;
        snap = dut_outs();
        return;
      end
    end
  endtask

  task automatic expect_event(input string name);
    bit   seen;
    int   at;
    exp_t e;
    wait_change(12, seen, at);
    checks++;
    if (!seen || sb.size() == 0) begin
      errors++;
      $display("FAIL %s: seen=%0b queued=%0d, required one output change", name, seen, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checks++;
    if (at !== e.at_edge) begin
      errors++;
      $display("FAIL %s edge: got %0d, required %0d", name, at, e.at_edge);
    end
    checks++;
    if (snap !== e.outs) begin
      errors++;
      $display("FAIL %s outs {x,y,s,ledr}: got %h, required %h", name, snap, e.outs);
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit seen;
    int at;
    wait_change(cycles, seen, at);
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL %s: unexpected output change at edge %0d to %h, required %h", name, at, snap,
               model_outs());
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    sw = 8'hFF;
    #1;
    checks++;
    if (dut_outs() !== 21'h0) begin
      errors++;
      $display("FAIL reset_async: got %h, required 0", dut_outs());
    end
    for (int i = 0; i < 6; i++) begin
      {key1, key2, key3} = 3'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (dut_outs() !== 21'h0) begin
        errors++;
        $display("FAIL reset_post_edge: got %h, required 0", dut_outs());
      end
      @(negedge clk);
      checks++;
      if (dut_outs() !== 21'h0) begin
        errors++;
        $display("FAIL reset_between_edges: got %h, required 0", dut_outs());
      end
    end
    {key1, key2, key3} = 3'b111;
    rst_n = 1'b1;
    snap = '0;
    expect_quiet("reset_release_idle", 8);
  endtask

  task automatic test_load_x();
    int e0;
    sw = 8'hA5;
    repeat (3) @(negedge clk);
    key1 = 1'b0;
    e0 = edge_cnt + 1;
    mx = 8'hA5;
    mxl = 1'b1;
    sb.push_back('{e0 + 5, model_outs()});
    expect_event("load_x");
    expect_quiet("load_x_held", 20);
    key1 = 1'b1;
    expect_quiet("load_x_release", 10);
  endtask

  task automatic test_bounce_load_y();
    int e0;
    sw = 8'h81;
    for (int r = 0; r < 5; r++) begin
      key2 = 1'b0;
      repeat (3) @(negedge clk);
      key2 = 1'b1;
      @(negedge clk);
    end
    expect_quiet("bounce_y", 6);
    checks++;
    if (y !== my) begin
      errors++;
      $display("FAIL bounce_y_value: got %h, required %h", y, my);
    end
    sw = 8'h3C;
    repeat (3) @(negedge clk);
    key2 = 1'b0;
    e0 = edge_cnt + 1;
    my = 8'h3C;
    myl = 1'b1;
    sb.push_back('{e0 + 5, model_outs()});
    expect_event("load_y");
    expect_quiet("load_y_held", 8);
    key2 = 1'b1;
    expect_quiet("load_y_release", 10);
  endtask

  task automatic test_select_toggle();
    int e0;
    for (int r = 0; r < 3; r++) begin
      key3 = 1'b0;
      e0 = edge_cnt + 1;
      ms = ~ms;
      sb.push_back('{e0 + 5, model_outs()});
      expect_event("toggle_s");
      repeat (4) @(negedge clk);
      key3 = 1'b1;
      expect_quiet("toggle_s_release", 10);
    end
  endtask

  task automatic test_simultaneous();
    int e0;
    sw = 8'h5A;
    repeat (3) @(negedge clk);
    key1 = 1'b0;
    key2 = 1'b0;
    e0 = edge_cnt + 1;
    mx = 8'h5A;
    my = 8'h5A;
    sb.push_back('{e0 + 5, model_outs()});
    expect_event("simultaneous_xy");
    key1 = 1'b1;
    key2 = 1'b1;
    expect_quiet("simultaneous_release", 12);
  endtask

  task automatic test_reset_mid_press();
    int d0;
    sw = 8'h77;
    repeat (3) @(negedge clk);
    key1 = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    {mx, my, ms, mxl, myl} = '0;
    checks++;
    if (dut_outs() !== model_outs()) begin
      errors++;
      $display("FAIL reset_mid_press_async: got %h, required %h", dut_outs(), model_outs());
    end
    snap = model_outs();
    expect_quiet("reset_mid_press_hold", 3);
    rst_n = 1'b1;
    d0 = edge_cnt + 1;
    mx = 8'h77;
    mxl = 1'b1;
    sb.push_back('{d0 + 5, model_outs()});
    expect_event("reload_after_reset");
    expect_quiet("reload_after_reset_once", 12);
    key1 = 1'b1;
    expect_quiet("reload_release", 10);
  endtask

  initial begin
    test_reset();
    test_load_x();
    test_bounce_load_y();
    test_select_toggle();
    test_simultaneous();
    test_reset_mid_press();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
